decoder_scan: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable and two modes. In direct mode it decodes a sampled select value; in scan mode an internal divider and index counter walk the one-hot output across all 2^N lines. It drives row/digit-select lines such as multiplexed display digits and keypad rows. It replaces combinational 2-to-4 decoding wherever a clocked, glitch-free select is required.

---
 rtl/decoder_scan_pkg.sv | 22 ++
 rtl/scan_divider.sv | 30 +++
 rtl/decoder_scan.sv | 94 +++++++++
 tb/tb_decoder_scan.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the registered one-hot select decoder.
// Latency: n/a (package). Backpressure: n/a.
// Holds the mode encoding, the width ceiling and the one-hot builder.
package decoder_scan_pkg;

   localparam int MAX_N = 6;
   localparam int MAX_W = 1 << MAX_N;

   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   // Lines at or above 2^n are never set, so a caller can truncate freely.
   function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] idx, input int n);
      logic [MAX_W-1:0] v;
      v = '0;
      if (int'(idx) < (1 << n)) v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/scan_divider.sv
// Divide-by-DIV dwell counter; tc pulses while enabled on the last count.
// Latency: tc is combinational from the count register. Backpressure: en stalls, clr restarts at 0.
// Count is held whenever en is low, so a paused scan resumes mid-dwell.
module scan_divider #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;

   assign tc = en && (cnt_q == CW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tc ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot select decoder with direct and scan modes.
// Latency: 1 cycle from sampling edge to O. Backpressure: none; E low blanks O and freezes scan.
// DECODER_SCAN_ACTIVE_LOW_EN selects an inverted O (active line low, idle all ones).
module decoder_scan
   import decoder_scan_pkg::*;
#(
   parameter int N        = 2,
   parameter int SCAN_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             E,
   input  logic             mode,
   input  logic [N-1:0]     A,
   input  logic             a_valid,
   output logic [2**N-1:0]  O,
   output logic             o_valid,
   output logic [N-1:0]     scan_idx
);

   localparam int W = 1 << N;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
   localparam logic [W-1:0] O_IDLE = '1;
`else
   localparam logic [W-1:0] O_IDLE = '0;
`endif

   mode_e          mode_in, mode_q;
   logic           mode_chg, scan_en, div_tc;
   logic [N-1:0]   idx_q, idx_nxt;
   logic [W-1:0]   o_q, o_nxt;
   logic           vld_q, vld_nxt;

   assign mode_in  = mode_e'(mode);
   assign mode_chg = (mode_in != mode_q);
   assign scan_en  = E && (mode_in == MODE_SCAN) && !mode_chg;

   scan_divider #(.DIV(SCAN_DIV)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (mode_chg),
      .en    (scan_en),
      .tc    (div_tc)
   );

   // O is stored already in output polarity so the pins come straight off flops.
   always_comb begin
      idx_nxt = idx_q;
      o_nxt   = o_q;
      vld_nxt = vld_q;
      if (mode_chg) begin
         idx_nxt = '0;
         if (E && (mode_in == MODE_SCAN)) begin
            o_nxt   = W'(onehot('0, N)) ^ O_IDLE;
            vld_nxt = 1'b1;
         end else begin
            o_nxt   = O_IDLE;
            vld_nxt = 1'b0;
         end
      end else if (!E) begin
         o_nxt   = O_IDLE;
         vld_nxt = 1'b0;
      end else if (mode_in == MODE_SCAN) begin
         if (div_tc) idx_nxt = idx_q + 1'b1;
         o_nxt   = W'(onehot(MAX_N'(idx_nxt), N)) ^ O_IDLE;
         vld_nxt = 1'b1;
      end else if (a_valid) begin
         idx_nxt = A;
         o_nxt   = W'(onehot(MAX_N'(A), N)) ^ O_IDLE;
         vld_nxt = 1'b1;
      end
   end

   // The mode register tracks the input even while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_DIRECT;
         idx_q  <= '0;
         o_q    <= O_IDLE;
         vld_q  <= 1'b0;
      end else begin
         mode_q <= mode_in;
         idx_q  <= idx_nxt;
         o_q    <= o_nxt;
         vld_q  <= vld_nxt;
      end
   end

   assign O        = o_q;
   assign o_valid  = vld_q;
   assign scan_idx = idx_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: directed table, scan sweep, mode switch,
// async reset and a randomized run against a dwell-count reference model.
module tb_decoder_scan;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
   localparam int N        = 4;
   localparam int SCAN_DIV = 1;
`else
   localparam int N        = 2;
   localparam int SCAN_DIV = 4;
`endif
   localparam int W = 1 << N;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          E;
   logic          mode;
   logic [N-1:0]  A;
   logic          a_valid;
   logic [W-1:0]  O;
   logic          o_valid;
   logic [N-1:0]  scan_idx;

   logic [W-1:0]  idle_o;

   int checks = 0;
   int errors = 0;

   // Reference model: k counts enabled scan edges since scan entry.
   int m_mode, m_k, m_last, m_act;

   decoder_scan #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .E        (E),
      .mode     (mode),
      .A        (A),
      .a_valid  (a_valid),
      .O        (O),
      .o_valid  (o_valid),
      .scan_idx (scan_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit e;
      bit m;
      int a;
      bit av;
      bit act;
      int idx;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_o(input int act, input int idx);
      logic [W-1:0] v;
      v = '0;
      if (act != 0) v[idx] = 1'b1;
      return v ^ idle_o;
   endfunction

   function automatic int m_idx();
      return (m_mode != 0) ? (m_k / SCAN_DIV) % W : m_last;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_k = 0; m_last = 0; m_act = 0;
   endtask

   task automatic model_step(input bit e_i, input bit m_i, input int a_i, input bit av_i);
      if (int'(m_i) != m_mode) begin
         m_mode = m_i;
         m_k    = 0;
         m_last = 0;
         m_act  = (e_i && m_i) ? 1 : 0;
      end else if (!e_i) begin
         m_act = 0;
      end else if (m_i) begin
         m_k++;
         m_act = 1;
      end else if (av_i) begin
         m_last = a_i;
         m_act  = 1;
      end
   endtask

   task automatic tick(input bit e_i, input bit m_i, input int a_i, input bit av_i);
      E       = e_i;
      mode    = m_i;
      A       = N'(a_i);
      a_valid = av_i;
      @(posedge clk);
      model_step(e_i, m_i, a_i, av_i);
      #1;
   endtask

   task automatic expect_out(input string tag, input int act, input int idx);
      chk({tag, ".O"}, 64'(O), 64'(exp_o(act, idx)));
      chk({tag, ".o_valid"}, 64'(o_valid), 64'(act));
      chk({tag, ".scan_idx"}, 64'(scan_idx), 64'(idx));
   endtask

   task automatic check_model(input string tag);
      expect_out(tag, m_act, m_idx());
      chk({tag, ".onehot"}, 64'($countones(O ^ idle_o) > 1), 64'(0));
   endtask

   initial begin
      int j;
      int target;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
      idle_o = '1;
`else
      idle_o = '0;
`endif
      tbl[0] = '{1, 0, 2, 1, 1, 2};
      tbl[1] = '{1, 0, 1, 0, 1, 2};
      tbl[2] = '{0, 0, 3, 1, 0, 2};
      tbl[3] = '{1, 0, 3, 0, 0, 2};
      tbl[4] = '{1, 0, 1, 1, 1, 1};
      tbl[5] = '{1, 0, 3, 1, 1, 3};
      tbl[6] = '{1, 0, 0, 1, 1, 0};

      rst_n = 1'b0; E = 1'b0; mode = 1'b0; A = '0; a_valid = 1'b0;
      model_reset();
      #2;
      expect_out("reset", 0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Direct decode, disable and re-enable from the table.
      for (int i = 0; i < 7; i++) begin
         tick(tbl[i].e, tbl[i].m, tbl[i].a, tbl[i].av);
         expect_out($sformatf("tbl%0d", i), tbl[i].act, tbl[i].idx);
      end

      // Full sweep plus wrap; a_valid pulses must not disturb it.
      for (j = 0; j <= W * SCAN_DIV; j++) begin
         tick(1'b1, 1'b1, int'($urandom_range(0, W - 1)), 1'($urandom));
         expect_out($sformatf("sweep%0d", j), 1, (j / SCAN_DIV) % W);
      end

      // Run on to the last index, then switch to direct and back to scan.
      target = (W - 1) * SCAN_DIV + W * SCAN_DIV;
      for (; j <= target; j++) begin
         tick(1'b1, 1'b1, 0, 1'b0);
      end
      expect_out("pre_switch", 1, W - 1);
      tick(1'b1, 1'b0, 0, 1'b0);
      expect_out("to_direct", 0, 0);
      for (int i = 0; i < SCAN_DIV; i++) begin
         tick(1'b1, 1'b1, 0, 1'b0);
         expect_out($sformatf("to_scan%0d", i), 1, 0);
      end
      tick(1'b1, 1'b1, 0, 1'b0);
      expect_out("to_scan_next", 1, 1);

      // Asynchronous reset between edges, then restart at index 0.
      #2 rst_n = 1'b0;
      #1;
      expect_out("async_rst", 0, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b1, 1'b1, 0, 1'b0);
      expect_out("rst_release", 1, 0);
      check_model("rst_release_m");

      // E falling together with a mode change: blanked, counters cleared.
      tick(1'b0, 1'b0, 0, 1'b0);
      expect_out("e_fall_chg", 0, 0);
      tick(1'b1, 1'b0, 0, 1'b0);
      expect_out("e_rise_noav", 0, 0);

      // Randomized run against the reference model.
      for (int i = 0; i < 400; i++) begin
         bit e_r, m_r;
         e_r = ($urandom_range(0, 99) < 85);
         m_r = ($urandom_range(0, 99) < 8) ? ~mode : mode;
         tick(e_r, m_r, int'($urandom_range(0, W - 1)), 1'($urandom));
         check_model($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
